// File: rtl/mmio_pkg.sv
// MMIO LED controller shared definitions.
// Register offsets, mode encodings and FSM state type.
package mmio_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_DUTY   = 5'h04;
  localparam logic [4:0] OFF_PERIOD = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_COUNT  = 5'h10;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    S_OFF,
    S_STATIC,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_PWM
  } state_e;

  // Reserved mode 2'b11 falls through to static.
  function automatic state_e entry_state(
    input logic [2:0] ctrl
  );
    if (!ctrl[0]) begin
      entry_state = S_OFF;
    end else begin
      case (ctrl[2:1])
        MODE_BLINK: entry_state = S_BLINK_ON;
        MODE_PWM:   entry_state = S_PWM;
        default:    entry_state = S_STATIC;
      endcase
    end
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running 8-bit PWM counter with duty compare.
// hit_o reflects the count the counter moves to at the next edge.
module led_pwm_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       run_i,
  input  logic [7:0] duty_i,
  output logic [7:0] cnt_o,
  output logic       hit_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr_i || !run_i) cnt_d = 8'd0;
  end

  assign hit_o = (cnt_d < duty_i);
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED controller: static, blink and PWM modes.
// 32-byte register window with W1C status and live counter readback.
module mmio_led_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        led
);

  import mmio_pkg::*;

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'd31;

  logic [2:0]          ctrl_q, ctrl_d;
  logic [7:0]          duty_q, duty_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, last;
  logic                evt_q, evt_d;
  logic                led_q, led_d;
  state_e              state_q, state_d;

  logic        wr_ok, ctrl_wr, duty_wr;
  logic        per_wr, stat_wr, ctrl_chg;
  logic        wrap, toggle, pwm_run, pwm_hit;
  logic [7:0]  pwm_cnt;
  logic [31:0] count_rd;

  assign sel = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
  assign led = led_q;

  assign wr_ok   = we && sel && (addr[1:0] == 2'b00);
  assign ctrl_wr = wr_ok && (addr[4:0] == OFF_CTRL);
  assign duty_wr = wr_ok && (addr[4:0] == OFF_DUTY);
  assign per_wr  = wr_ok && (addr[4:0] == OFF_PERIOD);
  assign stat_wr = wr_ok && (addr[4:0] == OFF_STATUS);

  assign ctrl_chg = ctrl_wr && (wdata[2:0] != ctrl_q);

  // PERIOD of 0 behaves as 1, so the last count is 0 either way.
  assign last = (period_q == '0) ? '0
              : period_q - PERIOD_W'(1);
  assign wrap = (cnt_q >= last);

  always_comb begin
    ctrl_d   = ctrl_wr ? wdata[2:0] : ctrl_q;
    duty_d   = duty_wr ? wdata[7:0] : duty_q;
    period_d = per_wr ? wdata[PERIOD_W-1:0]
                      : period_q;
    state_d  = state_q;
    cnt_d    = '0;
    toggle   = 1'b0;
    if (ctrl_chg) begin
      state_d = entry_state(wdata[2:0]);
    end else begin
      unique case (state_q)
        S_BLINK_ON, S_BLINK_OFF: begin
          if (wrap) begin
            toggle  = 1'b1;
            state_d = (state_q == S_BLINK_ON)
                    ? S_BLINK_OFF : S_BLINK_ON;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        default: ;
      endcase
    end
    evt_d = evt_q;
    if (stat_wr && wdata[1]) evt_d = 1'b0;
    if (toggle)              evt_d = 1'b1;
  end

  assign pwm_run = (state_d == S_PWM);

  led_pwm_gen u_pwm (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (ctrl_chg),
    .run_i  (pwm_run),
    .duty_i (duty_q),
    .cnt_o  (pwm_cnt),
    .hit_o  (pwm_hit)
  );

  always_comb begin
    led_d = 1'b0;
    unique case (state_d)
      S_STATIC:   led_d = 1'b1;
      S_BLINK_ON: led_d = 1'b1;
      S_PWM:      led_d = pwm_hit;
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      led_q    <= 1'b0;
      state_q  <= S_OFF;
    end else begin
      ctrl_q   <= ctrl_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      led_q    <= led_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    count_rd = '0;
    unique case (state_q)
      S_BLINK_ON, S_BLINK_OFF: count_rd = 32'(cnt_q);
      S_PWM:   count_rd = 32'(pwm_cnt);
      default: count_rd = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (re && sel) begin
      unique case ({addr[4:2], 2'b00})
        OFF_CTRL:   rdata = {29'd0, ctrl_q};
        OFF_DUTY:   rdata = {24'd0, duty_q};
        OFF_PERIOD: rdata = 32'(period_q);
        OFF_STATUS: rdata = {30'd0, evt_q, led_q};
        OFF_COUNT:  rdata = count_rd;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Directed bench for mmio_led_ctrl.
// Inputs driven on falling edges, outputs sampled there too.
module tb_mmio_led_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        sel;
  logic        led;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] r;
  logic [15:0] vec;
  int          hi;

  always #5 clk = ~clk;

  mmio_led_ctrl #(
    .BASE_ADDR (BASE),
    .PERIOD_W  (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .sel   (sel),
    .led   (led)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic wr(
    input logic [31:0] off,
    input logic [31:0] d
  );
    @(negedge clk);
    addr  = BASE + off;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    addr  = '0;
  endtask

  task automatic rd(
    input  logic [31:0] off,
    output logic [31:0] d
  );
    addr = BASE + off;
    re   = 1'b1;
    #1;
    d    = rdata;
    re   = 1'b0;
    addr = '0;
  endtask

  initial begin
    // reset held low for 10 cycles
    repeat (10) @(negedge clk);
    chk("rst_led_low", {31'd0, led}, 32'd0);
    rd(32'h0, r);
    chk("rst_rd_ctrl_in_reset", r, 32'd0);
    addr = BASE + 32'h1F;
    #1 chk("sel_top", {31'd0, sel}, 32'd1);
    addr = BASE + 32'h20;
    #1 chk("sel_past", {31'd0, sel}, 32'd0);
    addr = BASE - 32'd1;
    #1 chk("sel_below", {31'd0, sel}, 32'd0);
    addr = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_led", {31'd0, led}, 32'd0);
    for (int o = 0; o < 5; o++) begin
      rd(32'(o * 4), r);
      chk($sformatf("rst_reg%0h", o * 4), r, 32'd0);
    end

    // blink, period 4
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h3);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      vec[i] = led;
    end
    chk("blink_pat", {16'd0, vec}, 32'h0F0F);
    rd(32'hC, r);
    chk("evt_set", r, 32'h2);
    wr(32'hC, 32'h2);
    rd(32'hC, r);
    chk("evt_clr", r, 32'h1);
    rd(32'h10, r);
    chk("blink_cnt", r, 32'd1);
    @(negedge clk);
    wr(32'hC, 32'h2);
    rd(32'hC, r);
    chk("w1c_set_wins", r, 32'h2);

    // switch to static mid-period
    @(negedge clk);
    wr(32'h0, 32'h1);
    chk("static_led", {31'd0, led}, 32'd1);
    rd(32'h10, r);
    chk("static_cnt", r, 32'd0);
    repeat (3) @(negedge clk);
    chk("static_hold", {31'd0, led}, 32'd1);

    // rewrite of same CTRL keeps counting
    wr(32'h0, 32'h3);
    wr(32'h0, 32'h3);
    rd(32'h10, r);
    chk("ctrl_same_cnt", r, 32'd2);
    chk("ctrl_same_led", {31'd0, led}, 32'd1);

    // PERIOD 0 toggles every cycle
    wr(32'h8, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vec[i] = led;
    end
    chk("p0_toggle", {28'd0, vec[3:0]}, 32'hA);

    // reset pulse mid-blink
    wr(32'h8, 32'd4);
    repeat (2) @(negedge clk);
    chk("pre_rst_led", {31'd0, led}, 32'd1);
    reset = 1'b0;
    #1 chk("rst_async_led", {31'd0, led}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_led", {31'd0, led}, 32'd0);
    rd(32'h0, r);
    chk("post_rst_ctrl", r, 32'd0);
    rd(32'h8, r);
    chk("post_rst_period", r, 32'd0);
    rd(32'hC, r);
    chk("post_rst_status", r, 32'd0);
    rd(32'h10, r);
    chk("post_rst_count", r, 32'd0);

    // PWM
    wr(32'h4, 32'd64);
    rd(32'h4, r);
    chk("duty_rd", r, 32'd64);
    wr(32'h0, 32'h5);
    repeat (3) @(negedge clk);
    rd(32'h10, r);
    chk("pwm_cnt", r, 32'd3);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(led);
    end
    chk("pwm_duty64", 32'(hi), 32'd64);
    wr(32'h4, 32'd255);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(led);
    end
    chk("pwm_duty255", 32'(hi), 32'd255);
    wr(32'h4, 32'd0);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(led);
    end
    chk("pwm_duty0", 32'(hi), 32'd0);

    // decode
    wr(32'h20, 32'h0);
    wr(32'h02, 32'h0);
    rd(32'h0, r);
    chk("dec_ignored", r, 32'h5);
    rd(32'h14, r);
    chk("dec_unmapped", r, 32'd0);
    addr = BASE;
    re   = 1'b0;
    #1 chk("dec_no_re", rdata, 32'd0);
    addr = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_led_ctrl.md
MMIO_LED_CTRL -- requirements
Module: mmio_led_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, base of the 32-byte register window.
REQ-002 Parameter PERIOD_W, default 24, width of the blink half-period counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  32  CPU data-bus byte address.
REQ-006 wdata  input  32  CPU store data.
REQ-007 we  input  1  store strobe; sampled at the rising edge.
REQ-008 re  input  1  load strobe.
REQ-009 rdata  output  32  load data, combinational from addr.
REQ-010 sel  output  1  high when addr lies in [BASE_ADDR, BASE_ADDR+0x1F].
REQ-011 led  output  1  registered LED drive.

Function
REQ-012 Register map, word aligned: 0x00 CTRL (bit0 en, bits2:1 mode: 00 static, 01 blink, 10 pwm, 11 reserved, treated as static); 0x04 DUTY [7:0]; 0x08 PERIOD [PERIOD_W-1:0]; 0x0C STATUS, read-only except W1C (bit0 led, bit1 toggle_evt, sticky); 0x10 COUNT, read-only current counter value.
REQ-013 Write takes effect at the edge where we=1 and sel=1; writes outside the window, to read-only fields or to addr[1:0]!=0 are ignored.
REQ-014 rdata is the zero-extended register selected by addr[4:2] when re=1 and sel=1, else 32'h0; unmapped offsets read 0.
REQ-015 FSM states: OFF, STATIC, BLINK_ON, BLINK_OFF, PWM.
REQ-016 OFF when en=0: led=0 and counters held at 0.
REQ-017 STATIC: led=1.
REQ-018 BLINK_ON/BLINK_OFF: led=1/0; the counter counts 0..PERIOD-1, then wraps to 0, toggles state and sets toggle_evt.
REQ-019 PERIOD=0 in blink mode behaves as PERIOD=1: toggle every cycle.
REQ-020 PWM: an 8-bit counter runs free 0..255 and wraps; led=1 while counter<DUTY; DUTY=0 gives constant 0, DUTY=255 gives 1 for 255 of 256 cycles.
REQ-021 A CTRL write that changes en or mode resets all counters to 0 at the same edge; next state: blink enters BLINK_ON, pwm enters PWM, static enters STATIC, en=0 enters OFF.
REQ-022 A CTRL write with unchanged en and mode leaves state and counters untouched.
REQ-023 A PERIOD write during blink takes effect at the next wrap; if the new value is <= the current count, wrap occurs on the next cycle.
REQ-024 A DUTY write takes effect on the cycle after the write edge.
REQ-025 Same-edge W1C of toggle_evt and a new toggle event: set wins.
REQ-026 led is a flop output; latency from a CTRL write edge to the new led value is one cycle.

Reset
REQ-027 reset low forces immediately: CTRL=0, DUTY=0, PERIOD=0, STATUS=0, counters=0, state=OFF, led=0.
REQ-028 Reset asserted mid-blink or mid-PWM aborts the operation with no residual state; after release the block stays OFF until CTRL is written.
REQ-029 rdata and sel stay combinational and valid during reset; register reads return reset values.

Structure
REQ-030 Package mmio_pkg holds the register offset localparams, the mode enum (MODE_STATIC, MODE_BLINK, MODE_PWM) and the FSM state typedef.
REQ-031 One sub-module, led_pwm_gen, holds the 8-bit PWM counter and compare; the rest is flat.

Verification
REQ-032 Reset: hold reset=0 10 cycles, release -> led=0, all five registers read 0.
REQ-033 Blink: PERIOD=4, CTRL=0x3 -> led high 4 cycles, low 4 cycles, repeating; STATUS bit1=1 after the first toggle; writing 0x2 to STATUS clears it.
REQ-034 PWM: DUTY=64, CTRL=0x5 -> over any 256-cycle window led is high exactly 64 cycles; DUTY=0 -> led constant 0.
REQ-035 Mode switch and reset mid-run: CTRL 0x3->0x1 mid-period -> led=1 next cycle, COUNT=0; reset pulsed mid-blink -> led=0 and state OFF after release.
REQ-036 Decode: store to BASE_ADDR+0x20 and to BASE_ADDR+0x02 -> no register change; load from 0x14 -> rdata=0.
